// File: rtl/fetch_pkg.sv
// Shared constants, FSM state encoding and queue entry layout for the instruction fetch block.
package fetch_pkg;
  localparam int ADDR_W = 12;
  localparam int INST_W = 19;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam int DEPTH = 2;

  typedef enum logic [1:0] {
    FETCH,
    HALT_PEND,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Two-entry fetch FIFO; a push is visible at the head the following cycle.
// A push into a full queue is accepted only together with a pop; flush beats push and pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_dat_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);
  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop_eff, push_eff;

  assign pop_eff  = pop_i && (count_q != 2'd0);
  assign push_eff = push_i && ((count_q != 2'd2) || pop_eff);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({push_eff, pop_eff})
        2'b10: begin
          if (count_q == 2'd0) head_d = push_dat_i;
          else                 tail_d = push_dat_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever survives the pop.
          if (count_q == 2'd1) begin
            head_d = push_dat_i;
          end else begin
            head_d = tail_q;
            tail_d = push_dat_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = (count_q != 2'd0) ? head_q : '0;
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, queues fetched words for decode, handles redirects and halt.
// Word fetched in cycle N is presented in N+1; instReady low stalls. FETCH_SEQ_PERF_EN adds counters.
module fetch_sequencer
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imemPC,
  input  logic [INST_W-1:0] imemInst,
  input  logic              imemHalt,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic              instReady,
  output logic              instValid,
  output logic [INST_W-1:0] instOut,
  output logic [ADDR_W-1:0] pcOut,
  output logic              halted
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]       fetchCount,
  output logic [15:0]       stallCount
`endif
);
  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count;
  fetch_entry_t      head;
  fetch_entry_t      push_dat;
  logic              pop, push;

  assign instValid = (count != 2'd0);
  assign pop       = instValid && instReady;
  assign instOut   = head.inst;
  assign pcOut     = head.pc;
  assign imemPC    = pc_q;
  assign halted    = (state_q == HALTED);
  assign push_dat  = '{inst: imemInst, pc: pc_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (branchTaken) begin
      state_d = FETCH;
      pc_d    = branchTarget;
    end else begin
      case (state_q)
        FETCH: begin
          if (imemHalt) begin
            state_d = HALT_PEND;
          end else if ((count != 2'd2) || pop) begin
            push = 1'b1;
            pc_d = pc_q + ADDR_W'(1);
          end
        end
        HALT_PEND: begin
          if ((count == 2'd0) || ((count == 2'd1) && pop)) state_d = HALTED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (branchTaken),
    .push_i    (push),
    .push_dat_i(push_dat),
    .pop_i     (pop),
    .count_o   (count),
    .head_o    (head)
  );

`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (push && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (instValid && !instReady && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign fetchCount = fetch_cnt_q;
  assign stallCount = stall_cnt_q;
`endif
endmodule
